oclib_csr_range_splitter: RTL and testbench
===========================================

# oclib_csr_range_splitter

Next-generation CSR tree splitter: routes one upstream CSR request to one of `Outputs` downstream CSR ports using per-output key/mask block-ID range decode. It also provides:
- priority resolution of overlapping ranges;
- an optional default route or error response for unmapped IDs;
- feedback taken only from the selected output;
- an optional timeout.

It sits at CSR tree branch points between a top-level CSR master and block-level CSR slaves.

## Interface
Parameters:
- `CsrType`, `oclib_pkg::csr_32_tree_s`: request struct for `in` and every `out`. It must contain `read`, `write`, `toblock[31:0]`, `address` and `wdata`.
- `CsrFbType`, `oclib_pkg::csr_32_fb_s`: feedback struct with `ready`, `error` and `rdata`.
- `Outputs`, 8: number of downstream ports, 1..32.
- `OutputBlockIdKey[Outputs-1:0]`, all `32'hffffffff`: match key. The value `ffffffff` means the port matches `toblock == i`.
- `OutputBlockIdMask[Outputs-1:0]`, all `32'h0`: mask applied to `toblock` before comparing with the key.
- `DefaultOutput`, -1: port that receives unmatched IDs. -1 means unmatched IDs receive an error response.
- `TimeoutCycles`, 1024: cycles to wait for `ready` before aborting. Used only with the timeout feature; must be ≥ 2.

Ports:
- `clock`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `in`, input, `CsrType`: upstream request.
- `inFb`, output, `CsrFbType`: upstream response.
- `out[Outputs-1:0]`, output, `CsrType`: downstream requests.
- `outFb[Outputs-1:0]`, input, `CsrFbType`: downstream responses.
- `errorPulse`, output, 1: one-cycle pulse on every error response the splitter generates itself (unmapped ID or timeout).

## Operation
- FSM states: `StIdle`, `StDecode`, `StIssue`, `StResp`, `StWait`.
- **StIdle:**
  - On `in.read || in.write`, capture `in` into an internal register and go to `StDecode`.
  - If `read` and `write` are both high, the request is treated as a write.
- **StDecode:**
  - Evaluate the match for every port `i`, using the key/mask rule above.
  - `sel` is the lowest-index matching port.
  - If nothing matches and `DefaultOutput >= 0`, `sel = DefaultOutput`.
  - If nothing matches and `DefaultOutput == -1`, go to `StResp` with `error = 1` and `rdata = 0`.
  - Otherwise go to `StIssue`.
- **StIssue:**
  - `out[sel]` carries the captured request with the `read`/`write` strobe held high.
  - Every other `out[j]` carries the captured payload with both strobes low.
  - Only `outFb[sel]` is observed. `ready` on any other port is ignored.
  - When `outFb[sel].ready` is sampled high:
    - drop the strobe;
    - register `error` and `rdata` from `outFb[sel]` (`rdata` is forced to 0 on writes);
    - go to `StResp`.
- **StResp:** `inFb.ready = 1` for exactly one cycle with the registered `error` and `rdata`. Then go to `StWait`.
- **StWait:** stay until `in.read` and `in.write` are both low, then go to `StIdle`. A held request is never re-executed.
- `inFb` fields are zero in every state except `StResp`.

## Timing
- Request first sampled at edge N (state `StIdle`).
- `StDecode` occupies cycle N+1.
- `out[sel]` strobe is high from cycle N+2.
- Downstream `ready` sampled at edge M means:
  - the strobe is low in cycle M+1;
  - `inFb.ready` is high in cycle M+1 only.
- Minimum latency from `in` strobe to `inFb.ready` is 3 cycles, which occurs when `ready` is returned in the first issue cycle.
- Unmapped ID: `inFb.ready` with `error = 1`, and `errorPulse`, both in cycle N+2.
- All outputs are registered.
- Reset values: all `out[*]` = 0, `inFb` = 0, `errorPulse` = 0, state `StIdle`, timeout counter = 0.
- Asserting `reset` mid-transaction clears all outputs immediately (asynchronously). No response is produced for the aborted request.

## Configuration
- Macro: `OC_CSR_RANGE_SPLITTER_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TimeoutCycles+1)` clears on entry to `StIssue` and increments each cycle in `StIssue`.
  - When it reaches `TimeoutCycles` without `ready`: drop the strobe, go to `StResp` with `error = 1` and `rdata = 0`, and pulse `errorPulse`.
  - If `ready` arrives in the same cycle the counter reaches `TimeoutCycles`, `ready` wins (normal response, no `errorPulse`).
- **Undefined:** no counter is built and `StIssue` waits indefinitely. `errorPulse` fires only for unmapped IDs.

## Test plan
- **Default decode:** read with `toblock = 3`, `Outputs = 8`; `outFb[3]` returns `ready` with `rdata = 32'hA5A5_0003` after 2 cycles → only `out[3].read` is high; `inFb.ready` pulses once with `rdata = A5A5_0003`; `error = 0`.
- **Range overlap:** keys `{0x100, 0x100}` with masks `{0x1f0, 0x100}` on ports `{0, 1}`; write with `toblock = 0x105` → only `out[0].write` fires (lowest index wins); `inFb.rdata = 0`.
- **Unmapped ID:** `toblock = 0x55`, `DefaultOutput = -1` → in cycle N+2, `inFb.ready = 1`, `error = 1`, `errorPulse = 1`; no `out` strobe at any time.
- **Stray ready:** `outFb[5].ready` held high while `sel = 2` → ignored; response is produced only after `outFb[2].ready`.
- **Timeout (macro on):** `TimeoutCycles = 16`, no `ready` returned → strobe drops after 16 issue cycles; `inFb.error = 1`; then a late `outFb.ready` is ignored.
- **Reset mid-issue:** assert `reset` during `StIssue` → all strobes and `inFb` are 0 immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/oclib_csr_range_splitter.sv
// -----------------------------------------------------------------------------
// oclib_pkg / oclib_csr_range_match / oclib_csr_range_splitter
//
// CSR tree branch splitter. One upstream CSR request is captured, decoded
// against per-output key/mask block-ID ranges, and issued to exactly one
// downstream port. Only the selected port's feedback is observed. Unmapped IDs
// either go to DefaultOutput or get a locally generated error response.
//
// Optional feature macro: OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
//   Defined   -> an issue-cycle counter aborts the request with error=1 after
//                TimeoutCycles cycles without ready.
//   Undefined -> no counter; StIssue waits for ready indefinitely.
//
// Ports (oclib_csr_range_splitter):
//   clock       in   single clock
//   reset       in   asynchronous, active-high reset
//   in          in   upstream request (CsrType)
//   inFb        out  upstream response (CsrFbType), non-zero only in StResp
//   out[]       out  downstream requests, strobe only on the selected port
//   outFb[]     in   downstream responses, only outFb[sel] is observed
//   errorPulse  out  one-cycle pulse on every locally generated error
// -----------------------------------------------------------------------------

package oclib_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] toblock;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_tree_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_fb_s;

endpackage

// Per-port block-ID matcher. A key of all ones means "match toblock == Index",
// otherwise the masked ID must equal the key.
//   toblock_i  in   captured block ID
//   hit_o      out  this port claims the ID
module oclib_csr_range_match #(
  parameter int          Index = 0,
  parameter logic [31:0] Key   = 32'hffffffff,
  parameter logic [31:0] Mask  = 32'h0
) (
  input  logic [31:0] toblock_i,
  output logic        hit_o
);

  assign hit_o = (Key == 32'hffffffff) ? (toblock_i == 32'(Index))
                                       : ((toblock_i & Mask) == Key);

endmodule

module oclib_csr_range_splitter #(
  parameter type                      CsrType           = oclib_pkg::csr_32_tree_s,
  parameter type                      CsrFbType         = oclib_pkg::csr_32_fb_s,
  parameter int                       Outputs           = 8,
  parameter logic [Outputs-1:0][31:0] OutputBlockIdKey  = {Outputs{32'hffffffff}},
  parameter logic [Outputs-1:0][31:0] OutputBlockIdMask = {Outputs{32'h0}},
  parameter int                       DefaultOutput     = -1,
  parameter int                       TimeoutCycles     = 1024
) (
  input  logic     clock,
  input  logic     reset,
  input  CsrType   in,
  output CsrFbType inFb,
  output CsrType   out   [Outputs-1:0],
  input  CsrFbType outFb [Outputs-1:0],
  output logic     errorPulse
);

  localparam int SelW = (Outputs > 1) ? $clog2(Outputs) : 1;

  // Reject configurations the decode cannot represent.
  if (Outputs < 1 || Outputs > 32 || TimeoutCycles < 2 ||
      DefaultOutput < -1 || DefaultOutput >= Outputs) begin : g_bad_cfg
    $error("oclib_csr_range_splitter: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StIssue,
    StResp,
    StWait
  } state_e;

  state_e          state_q, state_d;
  CsrType          req_q, req_d;
  logic [SelW-1:0] sel_q, sel_d;
  CsrType          out_q [Outputs-1:0];
  CsrType          out_d [Outputs-1:0];
  CsrFbType        inFb_q, inFb_d;
  logic            errPulse_q, errPulse_d;

  logic [Outputs-1:0] hit;
  logic               hit_any;
  logic [SelW-1:0]    hit_sel;
  CsrFbType           fb_sel;

`ifdef OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Decode runs on the captured request, so it is stable throughout StDecode.
  for (genvar i = 0; i < Outputs; i++) begin : g_match
    oclib_csr_range_match #(
      .Index (i),
      .Key   (OutputBlockIdKey[i]),
      .Mask  (OutputBlockIdMask[i])
    ) u_match (
      .toblock_i (req_q.toblock),
      .hit_o     (hit[i])
    );
  end

  assign hit_any = |hit;

  // Lowest-index match wins where ranges overlap.
  always_comb begin
    hit_sel = '0;
    for (int i = Outputs - 1; i >= 0; i--) begin
      if (hit[i]) hit_sel = SelW'(i);
    end
  end

  // Feedback from any other port is never looked at.
  assign fb_sel = outFb[sel_q];

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    sel_d      = sel_q;
    out_d      = out_q;
    inFb_d     = '0;
    errPulse_d = 1'b0;
`ifdef OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in.read || in.write) begin
          req_d      = in;
          // read+write together is a write
          req_d.read = in.read & ~in.write;
          state_d    = StDecode;
        end
      end

      StDecode: begin
        if (hit_any || DefaultOutput >= 0) begin
          sel_d = hit_any ? hit_sel : SelW'(DefaultOutput);
          // All ports see the payload; only the selected one sees a strobe.
          for (int j = 0; j < Outputs; j++) begin
            out_d[j]       = req_q;
            out_d[j].read  = req_q.read  & (SelW'(j) == sel_d);
            out_d[j].write = req_q.write & (SelW'(j) == sel_d);
          end
`ifdef OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = StIssue;
        end else begin
          inFb_d.ready = 1'b1;
          inFb_d.error = 1'b1;
          errPulse_d   = 1'b1;
          state_d      = StResp;
        end
      end

      StIssue: begin
        if (fb_sel.ready) begin
          for (int j = 0; j < Outputs; j++) begin
            out_d[j].read  = 1'b0;
            out_d[j].write = 1'b0;
          end
          inFb_d.ready = 1'b1;
          inFb_d.error = fb_sel.error;
          inFb_d.rdata = req_q.write ? '0 : fb_sel.rdata;
          state_d      = StResp;
        end
`ifdef OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
        // cnt_q counts completed issue cycles; the strobe is held for exactly
        // TimeoutCycles cycles. A ready in the last one still wins above.
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          for (int j = 0; j < Outputs; j++) begin
            out_d[j].read  = 1'b0;
            out_d[j].write = 1'b0;
          end
          inFb_d.ready = 1'b1;
          inFb_d.error = 1'b1;
          errPulse_d   = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end

      // inFb_d defaults to zero, so the response registered on entry is a
      // single-cycle pulse.
      StResp: state_d = StWait;

      // Hold off until the master drops its strobe so it is not re-executed.
      StWait: begin
        if (!in.read && !in.write) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      req_q      <= '0;
      sel_q      <= '0;
      inFb_q     <= '0;
      errPulse_q <= 1'b0;
      for (int j = 0; j < Outputs; j++) out_q[j] <= '0;
`ifdef OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sel_q      <= sel_d;
      inFb_q     <= inFb_d;
      errPulse_q <= errPulse_d;
      for (int j = 0; j < Outputs; j++) out_q[j] <= out_d[j];
`ifdef OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign inFb       = inFb_q;
  assign errorPulse = errPulse_q;
  for (genvar i = 0; i < Outputs; i++) begin : g_out
    assign out[i] = out_q[i];
  end

endmodule

// File: tb/tb_oclib_csr_range_splitter.sv
// Bench for oclib_csr_range_splitter. DUT0: 8 ports, default key/mask decode,
// unmapped IDs get an error. DUT1: 2 overlapping ranges, DefaultOutput = 1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_oclib_csr_range_splitter;
  import oclib_pkg::*;

  localparam int N0 = 8;
  localparam int N1 = 2;
  localparam int TO = 16;
  localparam logic [N1-1:0][31:0] K1 = {32'h100, 32'h100};
  localparam logic [N1-1:0][31:0] M1 = {32'h100, 32'h1f0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_32_tree_s in0, in1;
  csr_32_fb_s   inFb0, inFb1;
  csr_32_tree_s out0   [N0-1:0];
  csr_32_fb_s   outFb0 [N0-1:0];
  csr_32_tree_s out1   [N1-1:0];
  csr_32_fb_s   outFb1 [N1-1:0];
  logic         ep0, ep1;

  int n_cmp = 0;
  int n_bad = 0;

  oclib_csr_range_splitter #(
    .Outputs(N0), .TimeoutCycles(TO)
  ) u_dut0 (
    .clock(clk), .reset(rst), .in(in0), .inFb(inFb0),
    .out(out0), .outFb(outFb0), .errorPulse(ep0)
  );

  oclib_csr_range_splitter #(
    .Outputs(N1), .OutputBlockIdKey(K1), .OutputBlockIdMask(M1),
    .DefaultOutput(1), .TimeoutCycles(TO)
  ) u_dut1 (
    .clock(clk), .reset(rst), .in(in1), .inFb(inFb1),
    .out(out1), .outFb(outFb1), .errorPulse(ep1)
  );

  typedef struct {
    int          d;
    logic        rd, wr;
    logic [31:0] blk, addr, wdata;
    int          dly;      // issue cycles before ready is returned
    logic        ferr;
    logic [31:0] frd;
    int          stray;    // port holding a stray ready, -1 for none
    int          e_port;   // -1: locally generated error
    int          e_lat;    // negedges from request to inFb.ready
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_ep;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nports(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic csr_32_tree_s get_out(input int d, input int j);
    if (d == 0) return out0[j[2:0]];
    return out1[j[0]];
  endfunction

  function automatic csr_32_fb_s get_infb(input int d);
    return (d == 0) ? inFb0 : inFb1;
  endfunction

  function automatic logic get_ep(input int d);
    return (d == 0) ? ep0 : ep1;
  endfunction

  task automatic set_in(input int d, input csr_32_tree_s v);
    if (d == 0) in0 = v; else in1 = v;
  endtask

  task automatic set_fb(input int d, input int j, input csr_32_fb_s v);
    if (d == 0) outFb0[j[2:0]] = v; else outFb1[j[0]] = v;
  endtask

  // Reference decode: first port whose rule claims the ID, else the default.
  function automatic int ref_port(input int d, input logic [31:0] blk);
    for (int i = 0; i < nports(d); i++) begin
      logic [31:0] k, m;
      k = (d == 0) ? 32'hffffffff : K1[i[0]];
      m = (d == 0) ? 32'h0        : M1[i[0]];
      if (k == 32'hffffffff) begin
        if (blk == 32'(i)) return i;
      end else if ((blk & m) == k) return i;
    end
    return (d == 0) ? -1 : 1;
  endfunction

  function automatic vec_t mk(input int d, input logic rd, input logic wr,
                              input logic [31:0] blk, input int dly,
                              input logic ferr, input logic [31:0] frd,
                              input int stray, input int ep, input int lat,
                              input logic err, input logic [31:0] erd,
                              input logic eep);
    vec_t v;
    v.d = d; v.rd = rd; v.wr = wr; v.blk = blk; v.dly = dly;
    v.addr = $urandom; v.wdata = $urandom;
    v.ferr = ferr; v.frd = frd; v.stray = stray;
    v.e_port = ep; v.e_lat = lat; v.e_err = err; v.e_rdata = erd; v.e_ep = eep;
    return v;
  endfunction

  // Acts as master and as the downstream slave of the targeted DUT.
  task automatic run_vec(input vec_t v, input string tag);
    csr_32_tree_s rq, o;
    csr_32_fb_s   fb, f;
    int lat = 0, pulses = 0, ep_cnt = 0, ep_at = 0;
    int strb = 0, bad_strb = 0, junk = 0;
    logic        got_err = 1'b0;
    logic [31:0] got_rd = '0;
    rq = '0;
    rq.read = v.rd; rq.write = v.wr; rq.toblock = v.blk;
    rq.address = v.addr; rq.wdata = v.wdata;
    if (v.stray >= 0) begin
      fb = '0; fb.ready = 1'b1; fb.error = 1'b1; fb.rdata = 32'hBAD0BAD0;
      set_fb(v.d, v.stray, fb);
    end
    set_in(v.d, rq);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      for (int j = 0; j < nports(v.d); j++)
        if (j != v.stray) set_fb(v.d, j, '0);
      f = get_infb(v.d);
      if (get_ep(v.d)) begin ep_cnt++; ep_at = k; end
      if (f.ready) begin
        pulses++;
        if (lat == 0) begin lat = k; got_err = f.error; got_rd = f.rdata; end
      end else if (f.error || f.rdata != 0) junk++;
      for (int j = 0; j < nports(v.d); j++) begin
        o = get_out(v.d, j);
        if (o.read || o.write) begin
          if (j != v.e_port || o.write != v.wr || o.read != (v.rd & ~v.wr) ||
              o.address != v.addr || o.wdata != v.wdata || o.toblock != v.blk)
            bad_strb++;
          else begin
            strb++;
            if (strb == v.dly + 1) begin
              fb = '0; fb.ready = 1'b1; fb.error = v.ferr; fb.rdata = v.frd;
              set_fb(v.d, j, fb);
            end
          end
        end
      end
      if (lat != 0 && k == lat + 2) begin
        rq.read = 1'b0; rq.write = 1'b0; set_in(v.d, rq);
      end
      // late ready after the response must not do anything
      if (lat != 0 && k >= lat + 2 && v.e_port >= 0) begin
        fb = '0; fb.ready = 1'b1; fb.rdata = 32'h5A5A5A5A;
        set_fb(v.d, v.e_port, fb);
      end
      if (lat != 0 && k >= lat + 5) break;
    end
    for (int j = 0; j < nports(v.d); j++) set_fb(v.d, j, '0);
    set_in(v.d, '0);
    @(negedge clk);
    chk({tag, " latency"},      32'(lat),      32'(v.e_lat));
    chk({tag, " error"},        32'(got_err),  32'(v.e_err));
    chk({tag, " rdata"},        got_rd,        v.e_rdata);
    chk({tag, " ready_pulses"}, 32'(pulses),   32'd1);
    chk({tag, " errpulse_cnt"}, 32'(ep_cnt),   32'(v.e_ep));
    chk({tag, " errpulse_at"},  32'(ep_at),    v.e_ep ? 32'(v.e_lat) : 32'd0);
    chk({tag, " bad_strobe"},   32'(bad_strb), 32'd0);
    chk({tag, " strobe_cyc"},   32'(strb),     (v.e_port < 0) ? 32'd0 : 32'(v.e_lat - 2));
    chk({tag, " infb_idle"},    32'(junk),     32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    csr_32_tree_s rq;
    logic any;

    in0 = '0; in1 = '0;
    for (int j = 0; j < N0; j++) outFb0[j] = '0;
    for (int j = 0; j < N1; j++) outFb1[j] = '0;
    #1 rst = 1'b1;
    #11;
    any = 1'b0;
    for (int j = 0; j < N0; j++) any |= |out0[j];
    for (int j = 0; j < N1; j++) any |= |out1[j];
    chk("reset out",   32'(any),    32'd0);
    chk("reset inFb0", 32'(|inFb0), 32'd0);
    chk("reset inFb1", 32'(|inFb1), 32'd0);
    chk("reset ep",    32'(ep0 | ep1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    //             d rd wr blk       dly ferr frd          strb  port lat err rdata       ep
    tbl.push_back(mk(0, 1, 0, 32'h3,    2, 0, 32'hA5A50003, -1,   3, 5, 0, 32'hA5A50003, 0));
    tbl.push_back(mk(0, 0, 1, 32'h7,    0, 0, 32'hDEADBEEF, -1,   7, 3, 0, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 32'h0,    1, 1, 32'h12345678, -1,   0, 4, 1, 32'h12345678, 0));
    tbl.push_back(mk(0, 1, 0, 32'h55,   0, 0, 32'h0,        -1,  -1, 2, 1, 32'h0,        1));
    tbl.push_back(mk(0, 1, 1, 32'h5,    0, 0, 32'h1111,     -1,   5, 3, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 32'h8,    0, 0, 32'h0,        -1,  -1, 2, 1, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 32'hffffffff, 0, 0, 32'h0,    -1,  -1, 2, 1, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 32'h2,    3, 0, 32'hC0FFEE02,  5,   2, 6, 0, 32'hC0FFEE02, 0));
    tbl.push_back(mk(1, 0, 1, 32'h105,  0, 0, 32'hFFFF,     -1,   0, 3, 0, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 32'h55,   1, 0, 32'h77,       -1,   1, 4, 0, 32'h77,       0));
    tbl.push_back(mk(1, 1, 0, 32'h1f0,  0, 0, 32'h88,       -1,   1, 3, 0, 32'h88,       0));
    tbl.push_back(mk(0, 1, 0, 32'h6,   15, 0, 32'hABCD,     -1,   6, 18, 0, 32'hABCD,    0));
`ifdef OC_CSR_RANGE_SPLITTER_TIMEOUT_EN
    tbl.push_back(mk(0, 1, 0, 32'h4, 1000, 0, 32'h0,        -1,   4, 18, 1, 32'h0,       1));
`endif
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // reset while the strobe is up
    rq = '0; rq.read = 1'b1; rq.toblock = 32'h6;
    in0 = rq;
    repeat (4) @(negedge clk);
    chk("rst_mid pre strobe", 32'(out0[6].read), 32'd1);
    #2 rst = 1'b1;
    #1;
    any = 1'b0;
    for (int j = 0; j < N0; j++) any |= |out0[j];
    chk("rst_mid out",  32'(any),    32'd0);
    chk("rst_mid inFb", 32'(|inFb0), 32'd0);
    in0 = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(mk(0, 1, 0, 32'h6, 1, 0, 32'h600D0006, -1, 6, 4, 0, 32'h600D0006, 0), "post_rst");

    for (int r = 0; r < 30; r++) begin
      int p;
      v.d = int'($urandom_range(0, 1));
      v.rd = 1'($urandom_range(0, 1));
      v.wr = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 3) == 0) v.blk = $urandom;
      else if (v.d == 0) v.blk = 32'($urandom_range(0, 11));
      else v.blk = 32'h100 | 32'($urandom_range(0, 511));
      v.addr = $urandom; v.wdata = $urandom;
      v.dly = int'($urandom_range(0, 4));
      v.ferr = 1'($urandom_range(0, 1));
      v.frd = $urandom;
      v.stray = -1;
      p = ref_port(v.d, v.blk);
      v.e_port  = p;
      v.e_lat   = (p < 0) ? 2 : 3 + v.dly;
      v.e_err   = (p < 0) ? 1'b1 : v.ferr;
      v.e_rdata = (p < 0 || v.wr) ? 32'h0 : v.frd;
      v.e_ep    = (p < 0);
      run_vec(v, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
